// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state encodings and the error fill word for the AXI4-lite responder.
package axi_lite_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_FILL = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DELAY = 2'd1,
        W_RESP  = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RESP  = 2'd2
    } r_state_t;

endpackage

// File: rtl/simple_axi_lite_responder_if.sv
// AXI4-lite 32-bit bus bundle; master drives requests and response readies, slave drives the rest.
interface simple_axi_lite_responder_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/simple_axi_lite_ram.sv
// 2**DEPTH_LOG2 x 32 word store: one write port, one registered read port, contents never reset.
module simple_axi_lite_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/simple_axi_lite_responder.sv
// AXI4-lite memory responder: B/R valid LATENCY cycles after request; responses held until ready, no new request meanwhile.
// AXI_RESPONDER_ERR_INJECT_EN adds inject_rd/inject_mask to XOR a mask into returned read data.
module simple_axi_lite_responder
    import axi_lite_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    simple_axi_lite_responder_if.slave bus,
`ifdef AXI_RESPONDER_ERR_INJECT_EN
    input  logic        inject_rd,
    input  logic [31:0] inject_mask,
`endif
    output logic [31:0] write_count,
    output logic [31:0] read_count
);

    localparam logic [32:0] LIMIT    = 33'(64'd4 << DEPTH_LOG2);
    localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

    w_state_t    w_state, w_next;
    logic [7:0]  w_cnt, w_cnt_next;
    logic        aw_held, w_held, w_err_q;
    logic [31:0] aw_addr_q, w_dat_q;
    logic        aw_rdy, w_rdy, aw_hs, w_hs, b_vld, commit;
    logic [31:0] wr_addr, wr_dat, wr_off;
    logic        wr_map;

    r_state_t    r_state, r_next;
    logic [7:0]  r_cnt, r_cnt_next;
    logic [31:0] ar_addr_q, inj_q;
    logic        r_err_q, ar_rdy, ar_hs, r_vld, sample;
    logic [31:0] rd_addr, rd_off, ram_q;
    logic        rd_map;

    // Address/data used at commit time: captured value, or the bus value when both arrive on the commit cycle.
    assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
    assign wr_dat  = w_held  ? w_dat_q   : bus.wdata;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign wr_map  = (wr_addr[1:0] == 2'b00) && ({1'b0, wr_off} < LIMIT);

    assign rd_addr = (r_state == R_IDLE) ? bus.araddr : ar_addr_q;
    assign rd_off  = rd_addr - BASE_ADDR;
    assign rd_map  = (rd_addr[1:0] == 2'b00) && ({1'b0, rd_off} < LIMIT);

    assign aw_rdy = ~reset & (w_state == W_IDLE) & ~aw_held;
    assign w_rdy  = ~reset & (w_state == W_IDLE) & ~w_held;
    assign b_vld  = ~reset & (w_state == W_RESP);
    assign aw_hs  = bus.awvalid & aw_rdy;
    assign w_hs   = bus.wvalid & w_rdy;

    assign ar_rdy = ~reset & (r_state == R_IDLE);
    assign r_vld  = ~reset & (r_state == R_RESP);
    assign ar_hs  = bus.arvalid & ar_rdy;

    always_comb begin
        w_next     = w_state;
        w_cnt_next = w_cnt;
        commit     = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if ((aw_held | aw_hs) & (w_held | w_hs)) begin
                    if (LATENCY == 1) begin
                        commit = 1'b1;
                        w_next = W_RESP;
                    end else begin
                        w_next     = W_DELAY;
                        w_cnt_next = LAT_LOAD;
                    end
                end
            end
            W_DELAY: begin
                if (w_cnt <= 8'd1) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else begin
                    w_cnt_next = w_cnt - 8'd1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // A read sample colliding with a write commit waits one cycle so it sees the new word.
    always_comb begin
        r_next     = r_state;
        r_cnt_next = r_cnt;
        sample     = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    if (LATENCY == 1 && !commit) begin
                        sample = 1'b1;
                        r_next = R_RESP;
                    end else begin
                        r_next     = R_DELAY;
                        r_cnt_next = (LATENCY == 1) ? 8'd1 : LAT_LOAD;
                    end
                end
            end
            R_DELAY: begin
                if (r_cnt <= 8'd1) begin
                    if (!commit) begin
                        sample = 1'b1;
                        r_next = R_RESP;
                    end
                end else begin
                    r_cnt_next = r_cnt - 8'd1;
                end
            end
            R_RESP: begin
                if (bus.rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_dat_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state <= w_next;
            w_cnt   <= w_cnt_next;
            if (w_state == W_RESP && bus.bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
            if (aw_hs)  aw_addr_q <= bus.awaddr;
            if (w_hs)   w_dat_q   <= bus.wdata;
            if (commit) w_err_q   <= ~wr_map;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state <= r_next;
            r_cnt   <= r_cnt_next;
            if (ar_hs)  ar_addr_q <= bus.araddr;
            if (sample) r_err_q   <= ~rd_map;
        end
    end

`ifdef AXI_RESPONDER_ERR_INJECT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            inj_q <= '0;
        end else if (ar_hs) begin
            inj_q <= inject_rd ? inject_mask : 32'h0;
        end
    end
`else
    assign inj_q = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            write_count <= '0;
            read_count  <= '0;
        end else begin
            if (b_vld & bus.bready) write_count <= write_count + 32'd1;
            if (r_vld & bus.rready) read_count  <= read_count + 32'd1;
        end
    end

    simple_axi_lite_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (commit & wr_map & ~reset),
        .waddr (wr_off[DEPTH_LOG2+1:2]),
        .wdata (wr_dat),
        .re    (sample & ~reset),
        .raddr (rd_off[DEPTH_LOG2+1:2]),
        .rdata (ram_q)
    );

    assign bus.awready = aw_rdy;
    assign bus.wready  = w_rdy;
    assign bus.bvalid  = b_vld;
    assign bus.bresp   = (b_vld && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.arready = ar_rdy;
    assign bus.rvalid  = r_vld;
    assign bus.rresp   = (r_vld && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.rdata   = !r_vld ? 32'h0 : (r_err_q ? RD_ERR_FILL : (ram_q ^ inj_q));

endmodule

// File: tb/tb_simple_axi_lite_responder.sv
// Scoreboard bench for simple_axi_lite_responder: directed corner cases plus randomized serial traffic.
module tb_simple_axi_lite_responder;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          chk_data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] write_count, read_count;
`ifdef AXI_RESPONDER_ERR_INJECT_EN
    logic        inject_rd;
    logic [31:0] inject_mask;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_done = 0;
    int r_done = 0;

    logic [1:0] exp_b [$];
    rd_exp_t    exp_r [$];

    logic [31:0] mem_m [64];
    bit          known [64];

    simple_axi_lite_responder_if bus ();

    simple_axi_lite_responder #(
        .DEPTH_LOG2 (6),
        .BASE_ADDR  (32'h0),
        .LATENCY    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
`ifdef AXI_RESPONDER_ERR_INJECT_EN
        .inject_rd   (inject_rd),
        .inject_mask (inject_mask),
`endif
        .write_count (write_count),
        .read_count  (read_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference memory: word-addressed, only bytes 0..0xFF aligned are backed.
    function automatic bit is_mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h100);
    endfunction

    function automatic logic [1:0] model_wr(input logic [31:0] a, input logic [31:0] d);
        if (!is_mapped(a)) return 2'b10;
        mem_m[a[7:2]] = d;
        known[a[7:2]] = 1'b1;
        return 2'b00;
    endfunction

    function automatic rd_exp_t model_rd(input logic [31:0] a);
        rd_exp_t e;
        if (is_mapped(a)) begin
            e.data = mem_m[a[7:2]]; e.resp = 2'b00; e.chk_data = known[a[7:2]];
        end else begin
            e.data = 32'hDEADBEEF; e.resp = 2'b10; e.chk_data = 1'b1;
        end
        return e;
    endfunction

    // Response monitor and hold-stability checker.
    logic        pb_v = 1'b0, pb_r = 1'b0, pr_v = 1'b0, pr_r = 1'b0;
    logic [1:0]  pb_resp, pr_resp;
    logic [31:0] pr_data;

    always @(negedge clk) begin
        if (!reset) begin
            if (pb_v && !pb_r) begin
                chk("bvalid_held", 32'(bus.bvalid), 32'h1);
                chk("bresp_stable", 32'(bus.bresp), 32'(pb_resp));
            end
            if (pr_v && !pr_r) begin
                chk("rvalid_held", 32'(bus.rvalid), 32'h1);
                chk("rresp_stable", 32'(bus.rresp), 32'(pr_resp));
                chk("rdata_stable", bus.rdata, pr_data);
            end
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) timeout("unexpected_b");
                else chk("bresp", 32'(bus.bresp), 32'(exp_b.pop_front()));
                b_done++;
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) timeout("unexpected_r");
                else begin
                    rd_exp_t e;
                    e = exp_r.pop_front();
                    chk("rresp", 32'(bus.rresp), 32'(e.resp));
                    if (e.chk_data) chk("rdata", bus.rdata, e.data);
                end
                r_done++;
            end
        end
        pb_v = bus.bvalid & ~reset; pb_r = bus.bready; pb_resp = bus.bresp;
        pr_v = bus.rvalid & ~reset; pr_r = bus.rready; pr_resp = bus.rresp; pr_data = bus.rdata;
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int aw_dly,
                            input int w_dly, input int b_hold, input int exp_lat, input logic [1:0] resp);
        int aw_c, w_c, k;
        aw_c = 0; w_c = 0;
        exp_b.push_back(resp);
        @(posedge clk); #1;
        fork
            begin
                int n;
                repeat (aw_dly) begin @(posedge clk); #1; end
                bus.awaddr = addr; bus.awvalid = 1'b1;
                n = 0;
                @(negedge clk);
                while (!bus.awready && n < 100) begin @(negedge clk); n++; end
                if (!bus.awready) timeout("aw_handshake");
                aw_c = cyc;
                @(posedge clk); #1 bus.awvalid = 1'b0;
            end
            begin
                int n;
                repeat (w_dly) begin @(posedge clk); #1; end
                bus.wdata = data; bus.wvalid = 1'b1;
                n = 0;
                @(negedge clk);
                while (!bus.wready && n < 100) begin @(negedge clk); n++; end
                if (!bus.wready) timeout("w_handshake");
                w_c = cyc;
                @(posedge clk); #1 bus.wvalid = 1'b0;
            end
        join
        k = 0;
        @(negedge clk);
        while (!bus.bvalid && k < 100) begin @(negedge clk); k++; end
        if (!bus.bvalid) begin timeout("bvalid"); return; end
        chk("b_latency", 32'(cyc - ((aw_c > w_c) ? aw_c : w_c)), 32'(exp_lat));
        repeat (b_hold) begin
            chk("awready_while_bvalid", 32'(bus.awready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_hold,
                           input int exp_lat, input rd_exp_t e);
        int ar_c, k;
        exp_r.push_back(e);
        @(posedge clk); #1;
        repeat (ar_dly) begin @(posedge clk); #1; end
        bus.araddr = addr; bus.arvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.arready && k < 100) begin @(negedge clk); k++; end
        if (!bus.arready) timeout("ar_handshake");
        ar_c = cyc;
        @(posedge clk); #1 bus.arvalid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!bus.rvalid && k < 100) begin @(negedge clk); k++; end
        if (!bus.rvalid) begin timeout("rvalid"); return; end
        chk("r_latency", 32'(cyc - ar_c), 32'(exp_lat));
        repeat (r_hold) begin
            chk("arready_while_rvalid", 32'(bus.arready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus.rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r;
        rd_exp_t     e;
        logic [31:0] a, d;

        reset = 1'b1;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
`ifdef AXI_RESPONDER_ERR_INJECT_EN
        inject_rd = 1'b0; inject_mask = '0;
`endif
        for (int i = 0; i < 64; i++) begin mem_m[i] = '0; known[i] = 1'b0; end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 0);
        chk("rst_wready", 32'(bus.wready), 0);
        chk("rst_arready", 32'(bus.arready), 0);
        chk("rst_bvalid", 32'(bus.bvalid), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_bresp", 32'(bus.bresp), 0);
        chk("rst_rresp", 32'(bus.rresp), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_write_count", write_count, 0);
        chk("rst_read_count", read_count, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Basic write then read back.
        r = model_wr(32'h10, 32'h12345678);
        do_write(32'h10, 32'h12345678, 0, 0, 0, 2, r);
        e = model_rd(32'h10);
        do_read(32'h10, 0, 0, 2, e);

        // W leads AW by three cycles.
        r = model_wr(32'h20, 32'h0BADF00D);
        fork
            do_write(32'h20, 32'h0BADF00D, 3, 0, 1, 2, r);
            begin
                @(posedge clk);
                repeat (2) @(negedge clk);
                chk("awready_after_w_only", 32'(bus.awready), 1);
                chk("wready_after_w_only", 32'(bus.wready), 0);
            end
        join
        chk("write_count_t2", write_count, 32'(b_done));

        // Unmapped and misaligned accesses; word 0 must survive the misaligned write.
        r = model_wr(32'h0, 32'hCAFEF00D);
        do_write(32'h0, 32'hCAFEF00D, 0, 0, 0, 2, r);
        e = model_rd(32'h100);
        do_read(32'h100, 0, 0, 2, e);
        r = model_wr(32'h2, 32'hFFFFFFFF);
        do_write(32'h2, 32'hFFFFFFFF, 0, 0, 0, 2, r);
        e = model_rd(32'h0);
        do_read(32'h0, 0, 0, 2, e);

        // Long backpressure on both response channels.
        r = model_wr(32'h24, 32'h55AA33CC);
        do_write(32'h24, 32'h55AA33CC, 1, 2, 10, 2, r);
        e = model_rd(32'h24);
        do_read(32'h24, 0, 10, 2, e);
        chk("write_count_t4", write_count, 32'(b_done));
        chk("read_count_t4", read_count, 32'(r_done));

`ifdef AXI_RESPONDER_ERR_INJECT_EN
        r = model_wr(32'h40, 32'hA5A5A5A4);
        do_write(32'h40, 32'hA5A5A5A4, 0, 0, 0, 2, r);
        e = model_rd(32'h40);
        e.data = e.data ^ 32'h1;
        inject_rd = 1'b1; inject_mask = 32'h1;
        do_read(32'h40, 0, 0, 2, e);
        inject_rd = 1'b0; inject_mask = 32'h0;
        e = model_rd(32'h40);
        do_read(32'h40, 0, 0, 2, e);
`endif

        // Randomized serial traffic.
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel < 9) a = 32'h100 + ($urandom & 32'h0000FFFC);
            else              a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                r = model_wr(a, d);
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 2, r);
            end else begin
                e = model_rd(a);
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 4), 2, e);
            end
        end
        chk("write_count_rand", write_count, 32'(b_done));
        chk("read_count_rand", read_count, 32'(r_done));

        // Write commit and read sample land on the same cycle, same word.
        r = model_wr(32'h30, 32'h600DCAFE);
        e = model_rd(32'h30);
        fork
            do_write(32'h30, 32'h600DCAFE, 0, 0, 0, 2, r);
            do_read(32'h30, 0, 0, 3, e);
        join
        chk("write_count_t5", write_count, 32'(b_done));
        chk("read_count_t5", read_count, 32'(r_done));

        // Reset while the write is in its delay phase: no response, no commit.
        @(posedge clk); #1;
        bus.awaddr = 32'h30; bus.awvalid = 1'b1; bus.wdata = 32'h11111111; bus.wvalid = 1'b1;
        @(negedge clk);
        chk("abandon_aw_hs", 32'(bus.awready & bus.wready), 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        b_done = 0; r_done = 0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (6) begin @(negedge clk); if (bus.bvalid) seen = 1'b1; end
            chk("no_bvalid_after_reset", 32'(seen), 0);
        end
        chk("write_count_after_reset", write_count, 0);
        chk("read_count_after_reset", read_count, 0);
        e = model_rd(32'h30);
        do_read(32'h30, 0, 0, 2, e);
        chk("read_count_final", read_count, 32'(r_done));
        chk("exp_b_drained", 32'(exp_b.size()), 0);
        chk("exp_r_drained", 32'(exp_r.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
